pe_dot_fp: RTL and testbench

//  Streaming bf16 dot-product processing element. Accepts (a,b) operand pairs over a

---
 rtl/pe_pkg.sv | 9 +
 rtl/add_fp.sv | 62 ++++++
 rtl/mul_fp.sv | 41 ++++
 rtl/pe_dot_ctrl.sv | 61 ++++++
 rtl/pe_dot_fp.sv | 55 +++++
 tb/tb_pe_dot_fp.sv | 152 +++++++++++++++
 6 files changed

// File: rtl/pe_pkg.sv
// pe_pkg: bf16 format defaults, constants and the PE control state encoding.
package pe_pkg;
    localparam int DEF_EXP_BIT  = 8;
    localparam int DEF_MAT_BIT  = 7;
    localparam int DEF_DATA_BIT = DEF_EXP_BIT + DEF_MAT_BIT + 1;
    localparam logic [15:0] BF16_ZERO = 16'h0000;
    localparam logic [15:0] BF16_ONE  = 16'h3F80;
    typedef enum logic [1:0] {IDLE, ACC, DRAIN, OUT} state_t;
endpackage

// File: rtl/add_fp.sv
// add_fp: float add, round-to-nearest-even, subnormals flushed; optional output register.
module add_fp import pe_pkg::*; #(
    parameter int EXP_BIT         = DEF_EXP_BIT,
    parameter int MAT_BIT         = DEF_MAT_BIT,
    parameter int DATA_BIT        = EXP_BIT + MAT_BIT + 1,
    parameter int ENABLE_PIPELINE = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_BIT-1:0] a,
    input  logic [DATA_BIT-1:0] b,
    output logic [DATA_BIT-1:0] y
);
    localparam int E = EXP_BIT;
    localparam int M = MAT_BIT;
    localparam int W = M + 4;
    localparam logic [E+1:0] EMAX = (E+2)'((1 << E) - 1);
    localparam logic [DATA_BIT-1:0] QNAN = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
    logic [DATA_BIT-1:0] x, z, y_c, y_q;
    logic sx, sub, rnd;
    logic [E-1:0] ex, ez, d;
    logic [W-1:0] mx, mz0, mz;
    logic [W:0] s;
    logic [E+1:0] e, re;
    logic [E+M+1:0] r;
    always_comb begin
        {x, z} = (a[DATA_BIT-2:0] < b[DATA_BIT-2:0]) ? {b, a} : {a, b};
        sx = x[DATA_BIT-1];
        sub = x[DATA_BIT-1] ^ z[DATA_BIT-1];
        ex = x[DATA_BIT-2 -: E];
        ez = z[DATA_BIT-2 -: E];
        d = ex - ez;
        // three extra low bits hold guard, round and sticky
        mx = {1'b1, x[M-1:0], 3'b000};
        mz0 = {1'b1, z[M-1:0], 3'b000};
        mz = mz0 >> d;
        mz[0] = mz[0] | (|(mz0 & ~({W{1'b1}} << d)));
        s = sub ? {1'b0, mx} - {1'b0, mz} : {1'b0, mx} + {1'b0, mz};
        e = {2'b0, ex} + {{(E+1){1'b0}}, s[W]};
        s = s[W] ? {1'b0, s[W:2], |s[1:0]} : s;
        for (int i = 0; i < W; i++) begin
            if (!s[W-1] && s != 0) begin
                s = s << 1;
                e = e - 1'b1;
            end
        end
        rnd = s[2] & (s[1] | s[0] | s[3]);
        r = {e, s[W-2:3]} + {{(E+M+1){1'b0}}, rnd};
        re = r[E+M+1:M];
        y_c = (ex == '1) ? ((ez == '1 && sub) ? QNAN : x) :
              (ez == 0) ? ((ex == 0) ? {sx & z[DATA_BIT-1], {(DATA_BIT-1){1'b0}}} : x) :
              (s == 0) ? {DATA_BIT{1'b0}} :
              ($signed(re) <= 0) ? {sx, {(DATA_BIT-1){1'b0}}} :
              ($signed(re) >= $signed(EMAX)) ? {sx, {E{1'b1}}, {M{1'b0}}} :
              {sx, re[E-1:0], r[M-1:0]};
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) y_q <= '0;
        else y_q <= y_c;
    end
    assign y = (ENABLE_PIPELINE != 0) ? y_q : y_c;
endmodule

// File: rtl/mul_fp.sv
// mul_fp: combinational float multiply, round-to-nearest-even, subnormals flushed to zero.
module mul_fp import pe_pkg::*; #(
    parameter int EXP_BIT  = DEF_EXP_BIT,
    parameter int MAT_BIT  = DEF_MAT_BIT,
    parameter int DATA_BIT = EXP_BIT + MAT_BIT + 1
) (
    input  logic [DATA_BIT-1:0] a,
    input  logic [DATA_BIT-1:0] b,
    output logic [DATA_BIT-1:0] y
);
    localparam int E = EXP_BIT;
    localparam int M = MAT_BIT;
    localparam logic [E+1:0] BIAS = (E+2)'((1 << (E-1)) - 1);
    localparam logic [E+1:0] EMAX = (E+2)'((1 << E) - 1);
    localparam logic [DATA_BIT-1:0] QNAN = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
    logic sy, hi, g, st;
    logic [E-1:0] ea, eb;
    logic [2*M+1:0] pm;
    logic [M-1:0] frac;
    logic [E+1:0] e, re;
    logic [E+M+1:0] r;
    always_comb begin
        sy = a[DATA_BIT-1] ^ b[DATA_BIT-1];
        ea = a[DATA_BIT-2 -: E];
        eb = b[DATA_BIT-2 -: E];
        pm = (2*M+2)'({1'b1, a[M-1:0]}) * (2*M+2)'({1'b1, b[M-1:0]});
        hi = pm[2*M+1];
        frac = hi ? pm[2*M:M+1] : pm[2*M-1:M];
        g = hi ? pm[M] : pm[M-1];
        st = hi ? |pm[M-1:0] : |pm[M-2:0];
        e = {2'b0, ea} + {2'b0, eb} - BIAS + {{(E+1){1'b0}}, hi};
        // rounding carry ripples from the fraction straight into the exponent
        r = {e, frac} + {{(E+M+1){1'b0}}, g & (st | frac[0])};
        re = r[E+M+1:M];
        y = ((ea == '1 && (a[M-1:0] != 0 || eb == 0)) || (eb == '1 && (b[M-1:0] != 0 || ea == 0))) ? QNAN :
            (ea == '1 || eb == '1) ? {sy, {E{1'b1}}, {M{1'b0}}} :
            (ea == 0 || eb == 0 || $signed(re) <= 0) ? {sy, {(DATA_BIT-1){1'b0}}} :
            ($signed(re) >= $signed(EMAX)) ? {sy, {E{1'b1}}, {M{1'b0}}} :
            {sy, re[E-1:0], r[M-1:0]};
    end
endmodule

// File: rtl/pe_dot_ctrl.sv
// pe_dot_ctrl: vector FSM, element counter and operand/result handshake for pe_dot_fp.
module pe_dot_ctrl import pe_pkg::*; #(
    parameter int MAX_LEN = 256,
    parameter int CNT_BIT = $clog2(MAX_LEN) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_last,
    input  logic               out_ready,
    output logic               in_ready,
    output logic               accept,
    output logic               first,
    output logic               drain,
    output logic               out_valid,
    output logic [CNT_BIT-1:0] out_count,
    output logic               out_trunc
);
    state_t state, state_nx;
    logic alive, trunc_q, at_max, last;
    logic [CNT_BIT-1:0] cnt;
    // alive keeps in_ready low until the first edge after reset is released
    assign in_ready = alive && (state == IDLE || state == ACC);
    assign accept = in_valid & in_ready;
    assign first = cnt == '0;
    assign at_max = cnt == CNT_BIT'(MAX_LEN - 1);
    assign last = in_last | at_max;
    assign drain = state == DRAIN;
    assign out_valid = state == OUT;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, ACC: state_nx = accept ? (last ? DRAIN : ACC) : state;
            DRAIN:     state_nx = OUT;
            OUT:       state_nx = out_ready ? IDLE : OUT;
            default:   state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            alive <= 1'b0;
            cnt <= '0;
            trunc_q <= 1'b0;
            out_count <= '0;
            out_trunc <= 1'b0;
        end else begin
            state <= state_nx;
            alive <= 1'b1;
            if (accept) begin
                cnt <= cnt + 1'b1;
                trunc_q <= ~in_last & at_max;
            end
            if (drain) begin
                cnt <= '0;
                out_count <= cnt;
                out_trunc <= trunc_q;
            end
        end
    end
endmodule

// File: rtl/pe_dot_fp.sv
// pe_dot_fp: streaming bf16 dot-product PE; multiply stage then single-cycle accumulate,
// one result per vector.
module pe_dot_fp import pe_pkg::*; #(
    parameter int EXP_BIT  = DEF_EXP_BIT,
    parameter int MAT_BIT  = DEF_MAT_BIT,
    parameter int DATA_BIT = EXP_BIT + MAT_BIT + 1,
    parameter int MAX_LEN  = 256,
    parameter int CNT_BIT  = $clog2(MAX_LEN) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_BIT-1:0] in_a,
    input  logic [DATA_BIT-1:0] in_b,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_BIT-1:0] out_data,
    output logic [CNT_BIT-1:0]  out_count,
    output logic                out_trunc
);
    logic accept, first, drain, v_q, first_q;
    logic [DATA_BIT-1:0] prod, prod_q, acc, acc_in, sum;
    pe_dot_ctrl #(.MAX_LEN(MAX_LEN), .CNT_BIT(CNT_BIT)) u_ctrl (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .out_ready(out_ready),
        .in_ready(in_ready), .accept(accept), .first(first), .drain(drain),
        .out_valid(out_valid), .out_count(out_count), .out_trunc(out_trunc)
    );
    mul_fp #(.EXP_BIT(EXP_BIT), .MAT_BIT(MAT_BIT), .DATA_BIT(DATA_BIT)) u_mul (
        .a(in_a), .b(in_b), .y(prod)
    );
    // the first product of a vector is added to zero so acc never needs an explicit clear
    assign acc_in = first_q ? DATA_BIT'(BF16_ZERO) : acc;
    add_fp #(.EXP_BIT(EXP_BIT), .MAT_BIT(MAT_BIT), .DATA_BIT(DATA_BIT), .ENABLE_PIPELINE(0)) u_add (
        .clk(clk), .rst(rst), .a(acc_in), .b(prod_q), .y(sum)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q <= 1'b0;
            first_q <= 1'b0;
            prod_q <= '0;
            acc <= '0;
            out_data <= '0;
        end else begin
            v_q <= accept;
            if (accept) begin
                prod_q <= prod;
                first_q <= first;
            end
            if (v_q) acc <= sum;
            if (drain) out_data <= sum;
        end
    end
endmodule

// File: tb/tb_pe_dot_fp.sv
// tb_pe_dot_fp: directed bf16 dot-product vectors with hand-computed sums, MAX_LEN=4.
module tb_pe_dot_fp;
    import pe_pkg::*;
    logic clk, rst, in_valid, in_ready, in_last, out_valid, out_ready, out_trunc;
    logic [DEF_DATA_BIT-1:0] in_a, in_b, out_data;
    logic [2:0] out_count;
    int checks = 0;
    int failures = 0;

    pe_dot_fp #(.MAX_LEN(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .out_trunc(out_trunc)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic l);
        int n = 0;
        in_valid = 1;
        in_a = a;
        in_b = b;
        in_last = l;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check("send_timeout", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 0;
        in_last = 0;
    endtask

    task automatic expect_result(input string tag, input logic [15:0] d, input logic [2:0] c, input logic t);
        check({tag, "_drain_v"}, out_valid, 0);
        @(posedge clk); #1;
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_data"}, out_data, d);
        check({tag, "_count"}, out_count, c);
        check({tag, "_trunc"}, out_trunc, t);
        check({tag, "_in_ready"}, in_ready, 0);
    endtask

    task automatic fire(input string tag);
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        check({tag, "_fire_v"}, out_valid, 0);
        check({tag, "_fire_rdy"}, in_ready, 1);
    endtask

    task automatic reset_zero(input string tag);
        check({tag, "_rst_in_ready"}, in_ready, 0);
        check({tag, "_rst_out_valid"}, out_valid, 0);
        check({tag, "_rst_data"}, out_data, 0);
        check({tag, "_rst_count"}, out_count, 0);
        check({tag, "_rst_trunc"}, out_trunc, 0);
    endtask

    initial begin
        rst = 1;
        in_valid = 0;
        in_last = 0;
        in_a = '0;
        in_b = '0;
        out_ready = 0;
        #2 rst = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_zero("init");
        rst = 1;
        @(posedge clk); #1;
        check("init_ready", in_ready, 1);

        // 1*2 + 3*3 = 11
        send(BF16_ONE, 16'h4000, 0);
        send(16'h4040, 16'h4040, 1);
        expect_result("t1", 16'h4130, 2, 0);
        fire("t1");

        send(16'h4040, 16'h4040, 1);
        expect_result("t2", 16'h4110, 1, 0);
        fire("t2");

        send(BF16_ONE, 16'h4000, 0);
        send(16'h4040, 16'h4040, 1);
        expect_result("t3", 16'h4130, 2, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("t3_hold_v", out_valid, 1);
            check("t3_hold_data", out_data, 16'h4130);
            check("t3_hold_count", out_count, 2);
            check("t3_hold_rdy", in_ready, 0);
        end
        fire("t3");

        // four ones with no last close at MAX_LEN; the fifth pair is a fresh vector
        for (int i = 0; i < 4; i++) send(BF16_ONE, BF16_ONE, 0);
        expect_result("t4", 16'h4080, 4, 1);
        fire("t4");
        send(BF16_ONE, BF16_ONE, 1);
        expect_result("t4b", BF16_ONE, 1, 0);
        fire("t4b");

        // 2*2, bubble, 1*3 + 1*1 = 8; then -3 + 4 = 1 checks acc restart
        send(16'h4000, 16'h4000, 0);
        repeat (2) @(posedge clk);
        #1;
        send(BF16_ONE, 16'h4040, 0);
        send(BF16_ONE, BF16_ONE, 1);
        expect_result("t5a", 16'h4100, 3, 0);
        fire("t5a");
        send(16'h4040, 16'hBF80, 0);
        send(16'h4000, 16'h4000, 1);
        expect_result("t5b", BF16_ONE, 2, 0);
        fire("t5b");

        send(BF16_ONE, BF16_ONE, 0);
        send(16'h4000, 16'h4000, 0);
        rst = 0;
        #1;
        reset_zero("t6");
        repeat (2) @(posedge clk);
        #1;
        reset_zero("t6_hold");
        rst = 1;
        @(posedge clk); #1;
        send(BF16_ONE, BF16_ONE, 1);
        expect_result("t6", BF16_ONE, 1, 0);
        fire("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
